// File: rtl/xctcmsg_piton_pkg.sv
// Shared OpenPiton NoC message definitions for the flit bridge and its FU-side adapter.
// Covers the flit/message types, header length-field location and FSM state encodings.
package xctcmsg_piton_pkg;

  localparam int NOC_FLIT_WIDTH         = 64;
  localparam int NOC_MSG_PAYLOAD_LENGTH = 2;
  localparam int NOC_MSG_WIDTH          = NOC_FLIT_WIDTH * (NOC_MSG_PAYLOAD_LENGTH + 1);

  // Payload-length field of the OpenPiton header flit (bits 29:22)
  localparam int NOC_LEN_OFFSET = 22;
  localparam int NOC_LEN_WIDTH  = 8;

  typedef logic [NOC_FLIT_WIDTH-1:0] openpiton_flit_t;

  typedef struct packed {
    openpiton_flit_t                                    header;
    logic [NOC_FLIT_WIDTH*NOC_MSG_PAYLOAD_LENGTH-1:0]   payload;
  } openpiton_noc_t;

  typedef enum logic {
    TX_IDLE,
    TX_SEND
  } tx_state_e;

  typedef enum logic [1:0] {
    RX_HDR,
    RX_PAY,
    RX_DROP,
    RX_HOLD
  } rx_state_e;

  function automatic logic [NOC_LEN_WIDTH-1:0] noc_msg_len(input openpiton_flit_t hdr);
    return hdr[NOC_LEN_OFFSET +: NOC_LEN_WIDTH];
  endfunction

endpackage

// File: rtl/openpiton_flit_deserializer.sv
// RX half of the flit bridge: collects a header plus payload flits into one wide message
// and discards messages whose header length does not match the expected payload count.
module openpiton_flit_deserializer
  import xctcmsg_piton_pkg::*;
#(
  parameter int FLIT_WIDTH    = NOC_FLIT_WIDTH,
  parameter int PAYLOAD_FLITS = NOC_MSG_PAYLOAD_LENGTH,
  parameter int MSG_WIDTH     = FLIT_WIDTH * (PAYLOAD_FLITS + 1)
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  noc_in_val,
  output logic                  noc_in_rdy,
  input  logic [FLIT_WIDTH-1:0] noc_in_data,
  output logic                  fu_rx_val,
  input  logic                  fu_rx_rdy,
  output logic [MSG_WIDTH-1:0]  fu_rx_data,
  output logic                  rx_length_error
);

  localparam int PAY_WIDTH = MSG_WIDTH - FLIT_WIDTH;
  localparam logic [NOC_LEN_WIDTH-1:0] LEN_OK = NOC_LEN_WIDTH'(PAYLOAD_FLITS);

  rx_state_e                state_q, state_d;
  logic [NOC_LEN_WIDTH-1:0] remaining_q;
  logic [FLIT_WIDTH-1:0]    hdr_q;
  logic [PAY_WIDTH-1:0]     pay_q;
  logic                     err_q;
  logic                     in_hs;
  logic [NOC_LEN_WIDTH-1:0] in_len;

  assign in_hs           = noc_in_val && noc_in_rdy;
  assign in_len          = noc_msg_len(noc_in_data);
  assign fu_rx_data      = {hdr_q, pay_q};
  assign rx_length_error = err_q;

  always_ff @(posedge clk) begin
    if (rst) state_q <= RX_HDR;
    else     state_q <= state_d;
  end

  always_comb begin
    state_d    = state_q;
    noc_in_rdy = 1'b1;
    fu_rx_val  = 1'b0;
    case (state_q)
      RX_HDR: begin
        if (in_hs) begin
          if (in_len == LEN_OK)               state_d = RX_PAY;
          else if (in_len != '0)              state_d = RX_DROP;
        end
      end
      RX_PAY: begin
        if (in_hs && remaining_q == 8'd1)     state_d = RX_HOLD;
      end
      RX_DROP: begin
        if (in_hs && remaining_q == 8'd1)     state_d = RX_HDR;
      end
      RX_HOLD: begin
        noc_in_rdy = 1'b0;
        fu_rx_val  = 1'b1;
        if (fu_rx_rdy)                        state_d = RX_HDR;
      end
      default: state_d = RX_HDR;
    endcase
  end

  // remaining only ever decrements from a non-zero value, so it cannot wrap
  always_ff @(posedge clk) begin
    if (rst) begin
      remaining_q <= '0;
      err_q       <= 1'b0;
    end else begin
      err_q <= 1'b0;
      if (in_hs) begin
        case (state_q)
          RX_HDR: begin
            remaining_q <= in_len;
            if (in_len == '0) err_q <= 1'b1;
          end
          RX_PAY:  remaining_q <= remaining_q - 8'd1;
          RX_DROP: begin
            remaining_q <= remaining_q - 8'd1;
            if (remaining_q == 8'd1) err_q <= 1'b1;
          end
          default: remaining_q <= remaining_q;
        endcase
      end
    end
  end

  // Payload shifts in from the bottom so the first payload flit ends up just under the header
  always_ff @(posedge clk) begin
    if (in_hs && state_q == RX_HDR) hdr_q <= noc_in_data;
    if (in_hs && state_q == RX_PAY) pay_q <= (pay_q << FLIT_WIDTH) | PAY_WIDTH'(noc_in_data);
  end

endmodule

// File: rtl/openpiton_flit_bridge.sv
// NoC-side bridge: serialises wide FU messages into 64-bit flits and deserialises
// incoming flits back into wide messages. TX and RX paths are fully independent.
module openpiton_flit_bridge
  import xctcmsg_piton_pkg::*;
#(
  parameter int FLIT_WIDTH    = NOC_FLIT_WIDTH,
  parameter int PAYLOAD_FLITS = NOC_MSG_PAYLOAD_LENGTH,
  parameter int MSG_WIDTH     = FLIT_WIDTH * (PAYLOAD_FLITS + 1)
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  fu_tx_val,
  output logic                  fu_tx_rdy,
  input  logic [MSG_WIDTH-1:0]  fu_tx_data,
  output logic                  noc_out_val,
  input  logic                  noc_out_rdy,
  output logic [FLIT_WIDTH-1:0] noc_out_data,
  input  logic                  noc_in_val,
  output logic                  noc_in_rdy,
  input  logic [FLIT_WIDTH-1:0] noc_in_data,
  output logic                  fu_rx_val,
  input  logic                  fu_rx_rdy,
  output logic [MSG_WIDTH-1:0]  fu_rx_data,
  output logic                  rx_length_error
);

  localparam int TX_CNT_W = $clog2(PAYLOAD_FLITS + 1);
  localparam logic [TX_CNT_W-1:0] TX_LAST = TX_CNT_W'(PAYLOAD_FLITS);

  tx_state_e             tx_state_q, tx_state_d;
  logic [MSG_WIDTH-1:0]  tx_shift_q;
  logic [TX_CNT_W-1:0]   tx_cnt_q;

  // The current flit is always the top slice; each accepted flit shifts the next one up
  assign noc_out_data = tx_shift_q[MSG_WIDTH-1 -: FLIT_WIDTH];

  always_ff @(posedge clk) begin
    if (rst) tx_state_q <= TX_IDLE;
    else     tx_state_q <= tx_state_d;
  end

  always_comb begin
    tx_state_d  = tx_state_q;
    fu_tx_rdy   = 1'b0;
    noc_out_val = 1'b0;
    case (tx_state_q)
      TX_IDLE: begin
        fu_tx_rdy = 1'b1;
        if (fu_tx_val) tx_state_d = TX_SEND;
      end
      TX_SEND: begin
        noc_out_val = 1'b1;
        if (noc_out_rdy && tx_cnt_q == TX_LAST) tx_state_d = TX_IDLE;
      end
      default: tx_state_d = TX_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      tx_cnt_q <= '0;
    end else if (tx_state_q == TX_IDLE && fu_tx_val) begin
      tx_shift_q <= fu_tx_data;
      tx_cnt_q   <= '0;
    end else if (tx_state_q == TX_SEND && noc_out_rdy) begin
      tx_shift_q <= tx_shift_q << FLIT_WIDTH;
      if (tx_cnt_q != TX_LAST) tx_cnt_q <= tx_cnt_q + 1'b1;
    end
  end

  openpiton_flit_deserializer #(
    .FLIT_WIDTH    (FLIT_WIDTH),
    .PAYLOAD_FLITS (PAYLOAD_FLITS),
    .MSG_WIDTH     (MSG_WIDTH)
  ) u_deserializer (
    .clk             (clk),
    .rst             (rst),
    .noc_in_val      (noc_in_val),
    .noc_in_rdy      (noc_in_rdy),
    .noc_in_data     (noc_in_data),
    .fu_rx_val       (fu_rx_val),
    .fu_rx_rdy       (fu_rx_rdy),
    .fu_rx_data      (fu_rx_data),
    .rx_length_error (rx_length_error)
  );

endmodule

// File: tb/tb_openpiton_flit_bridge.sv
// Scoreboard bench for openpiton_flit_bridge: stimulus pushes expected flits/messages,
// a negedge monitor pops and compares them whenever the DUT completes a handshake.
module tb_openpiton_flit_bridge;
  import xctcmsg_piton_pkg::*;

  localparam int FW = NOC_FLIT_WIDTH;
  localparam int MW = NOC_MSG_WIDTH;

  logic          clk = 1'b0;
  logic          rst;
  logic          fu_tx_val;
  logic          fu_tx_rdy;
  logic [MW-1:0] fu_tx_data;
  logic          noc_out_val;
  logic          noc_out_rdy;
  logic [FW-1:0] noc_out_data;
  logic          noc_in_val;
  logic          noc_in_rdy;
  logic [FW-1:0] noc_in_data;
  logic          fu_rx_val;
  logic          fu_rx_rdy;
  logic [MW-1:0] fu_rx_data;
  logic          rx_length_error;

  logic          loopback;
  logic          tb_in_val;
  logic [FW-1:0] tb_in_data;
  logic          tb_out_rdy;

  assign noc_in_val  = loopback ? noc_out_val  : tb_in_val;
  assign noc_in_data = loopback ? noc_out_data : tb_in_data;
  assign noc_out_rdy = loopback ? noc_in_rdy   : tb_out_rdy;

  always #5 clk = ~clk;

  openpiton_flit_bridge dut (
    .clk             (clk),
    .rst             (rst),
    .fu_tx_val       (fu_tx_val),
    .fu_tx_rdy       (fu_tx_rdy),
    .fu_tx_data      (fu_tx_data),
    .noc_out_val     (noc_out_val),
    .noc_out_rdy     (noc_out_rdy),
    .noc_out_data    (noc_out_data),
    .noc_in_val      (noc_in_val),
    .noc_in_rdy      (noc_in_rdy),
    .noc_in_data     (noc_in_data),
    .fu_rx_val       (fu_rx_val),
    .fu_rx_rdy       (fu_rx_rdy),
    .fu_rx_data      (fu_rx_data),
    .rx_length_error (rx_length_error)
  );

  int check_count = 0;
  int pass_count  = 0;
  int tx_hs       = 0;
  int rx_hs       = 0;
  int err_pulses  = 0;

  logic [FW-1:0] tx_q[$];
  logic [MW-1:0] rx_q[$];

  logic          stall_prev = 1'b0;
  logic [FW-1:0] stall_data;

  task automatic checkOutput(input string name, input logic [MW-1:0] actual,
                             input logic [MW-1:0] expected);
    check_count++;
    if (actual === expected) pass_count++;
    else $display("[TB] FAIL %s: got %h, expected %h", name, actual, expected);
  endtask

  function automatic logic [FW-1:0] hdr(input int len, input logic [7:0] tag);
    logic [FW-1:0] h;
    h = {tag, 56'h0};
    h[NOC_LEN_OFFSET +: NOC_LEN_WIDTH] = 8'(len);
    return h;
  endfunction

  // Issue one wide message on the FU TX side; optionally expect it back on RX (loopback)
  task automatic applyStimulus(input logic [MW-1:0] msg, input bit expect_rx);
    int n = 0;
    for (int k = 0; k <= NOC_MSG_PAYLOAD_LENGTH; k++)
      tx_q.push_back(msg[MW-1-k*FW -: FW]);
    if (expect_rx) rx_q.push_back(msg);
    fu_tx_val  = 1'b1;
    fu_tx_data = msg;
    @(negedge clk);
    while (!fu_tx_rdy && n < 50) begin @(negedge clk); n++; end
    checkOutput("fu_tx_rdy_wait", fu_tx_rdy, 1);
    @(posedge clk); #1;
    fu_tx_val = 1'b0;
  endtask

  task automatic rxFlit(input logic [FW-1:0] d);
    int n = 0;
    tb_in_val  = 1'b1;
    tb_in_data = d;
    @(negedge clk);
    while (!noc_in_rdy && n < 50) begin @(negedge clk); n++; end
    checkOutput("noc_in_rdy_wait", noc_in_rdy, 1);
    @(posedge clk); #1;
    tb_in_val = 1'b0;
  endtask

  task automatic waitDrain();
    int n = 0;
    while ((tx_q.size() != 0 || rx_q.size() != 0) && n < 100) begin
      @(posedge clk); n++;
    end
    repeat (2) @(posedge clk);
    #1;
    checkOutput("queues_drained", MW'(tx_q.size() + rx_q.size()), 0);
  endtask

  task automatic checkResetState();
    @(negedge clk);
    checkOutput("rst_fu_tx_rdy", fu_tx_rdy, 1);
    checkOutput("rst_noc_out_val", noc_out_val, 0);
    checkOutput("rst_noc_in_rdy", noc_in_rdy, 1);
    checkOutput("rst_fu_rx_val", fu_rx_val, 0);
    checkOutput("rst_length_error", rx_length_error, 0);
  endtask

  // Monitor: compares every completed handshake against the scoreboards
  always @(negedge clk) begin
    if (rst) begin
      stall_prev = 1'b0;
    end else begin
      if (stall_prev) begin
        checkOutput("tx_stall_val", noc_out_val, 1);
        checkOutput("tx_stall_data", noc_out_data, stall_data);
      end
      if (noc_out_val && noc_out_rdy) begin
        tx_hs++;
        checkOutput("tx_flit_expected", tx_q.size() != 0, 1);
        if (tx_q.size() != 0) checkOutput("tx_flit", noc_out_data, tx_q.pop_front());
      end
      stall_prev = noc_out_val && !noc_out_rdy;
      stall_data = noc_out_data;
      if (fu_rx_val && fu_rx_rdy) begin
        rx_hs++;
        checkOutput("rx_msg_expected", rx_q.size() != 0, 1);
        if (rx_q.size() != 0) checkOutput("rx_msg", fu_rx_data, rx_q.pop_front());
      end
      if (rx_length_error) err_pulses++;
    end
  end

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] watchdog");
  end

  initial begin
    logic [MW-1:0] m;
    logic          pat[5];
    int            hs_before;
    int            rx_before;

    rst = 1'b1; fu_tx_val = 1'b0; fu_tx_data = '0; fu_rx_rdy = 1'b0;
    loopback = 1'b0; tb_in_val = 1'b0; tb_in_data = '0; tb_out_rdy = 1'b1;
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    checkResetState();
    @(posedge clk); #1;

    // Basic TX: flits on cycles 1..3, ready again on cycle 4
    $display("[TB] TX basic");
    applyStimulus({64'hA, 64'hB, 64'hC}, 1'b0);
    for (int c = 1; c <= 4; c++) begin
      @(negedge clk);
      checkOutput($sformatf("tx_rdy_c%0d", c), fu_tx_rdy, (c == 4));
      checkOutput($sformatf("tx_val_c%0d", c), noc_out_val, (c < 4));
      @(posedge clk); #1;
    end
    waitDrain();

    // TX with back-pressure
    $display("[TB] TX stall");
    pat = '{1'b1, 1'b0, 1'b0, 1'b1, 1'b1};
    hs_before = tx_hs;
    applyStimulus({64'hA0A0, 64'hB0B0, 64'hC0C0}, 1'b0);
    for (int i = 0; i < 5; i++) begin
      tb_out_rdy = pat[i];
      @(posedge clk); #1;
    end
    tb_out_rdy = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    checkOutput("tx_stall_handshakes", MW'(tx_hs - hs_before), 3);
    checkOutput("tx_stall_queue", MW'(tx_q.size()), 0);

    // RX with FU holding off
    $display("[TB] RX hold");
    m = {hdr(2, 8'hB1), 64'h11, 64'h22};
    rx_q.push_back(m);
    rxFlit(m[MW-1 -: FW]);
    rxFlit(64'h11);
    rxFlit(64'h22);
    tb_in_val  = 1'b1;
    tb_in_data = hdr(2, 8'hB2);
    for (int c = 0; c < 4; c++) begin
      @(negedge clk);
      checkOutput("hold_fu_rx_val", fu_rx_val, 1);
      checkOutput("hold_noc_in_rdy", noc_in_rdy, 0);
      checkOutput("hold_fu_rx_data", fu_rx_data, m);
      @(posedge clk); #1;
    end
    fu_rx_rdy = 1'b1;
    m = {hdr(2, 8'hB2), 64'h33, 64'h44};
    rx_q.push_back(m);
    rxFlit(m[MW-1 -: FW]);
    rxFlit(64'h33);
    rxFlit(64'h44);
    waitDrain();

    // RX length mismatch: discarded, then a good message goes through
    $display("[TB] RX bad length");
    rx_before = rx_hs;
    rxFlit(hdr(5, 8'hC1));
    for (int i = 1; i <= 5; i++) rxFlit(64'(i));
    @(negedge clk);
    checkOutput("len5_error_pulse", rx_length_error, 1);
    @(negedge clk);
    checkOutput("len5_error_clear", rx_length_error, 0);
    checkOutput("len5_no_delivery", MW'(rx_hs - rx_before), 0);
    checkOutput("len5_error_count", MW'(err_pulses), 1);
    @(posedge clk); #1;
    m = {hdr(2, 8'hC2), 64'h55, 64'h66};
    rx_q.push_back(m);
    rxFlit(m[MW-1 -: FW]);
    rxFlit(64'h55);
    rxFlit(64'h66);
    waitDrain();

    // Zero-length header
    $display("[TB] RX zero length");
    rxFlit(hdr(0, 8'hD0));
    @(negedge clk);
    checkOutput("len0_error_pulse", rx_length_error, 1);
    checkOutput("len0_stays_hdr", noc_in_rdy, 1);
    @(negedge clk);
    checkOutput("len0_error_clear", rx_length_error, 0);
    checkOutput("len0_error_count", MW'(err_pulses), 2);
    @(posedge clk); #1;

    // Loopback: three back-to-back messages
    $display("[TB] loopback");
    loopback = 1'b1;
    applyStimulus({hdr(2, 8'hE1), 64'h0101_0101, 64'h0202_0202}, 1'b1);
    applyStimulus({hdr(2, 8'hE2), 64'h0303_0303, 64'h0404_0404}, 1'b1);
    applyStimulus({hdr(2, 8'hE3), 64'h0505_0505, 64'h0606_0606}, 1'b1);
    waitDrain();
    checkOutput("loopback_rx_count", MW'(rx_hs), 6);

    // Loopback with reset in the middle of the second message
    $display("[TB] loopback reset");
    applyStimulus({hdr(2, 8'hF1), 64'h0707, 64'h0808}, 1'b1);
    waitDrain();
    rx_before = rx_hs;
    applyStimulus({hdr(2, 8'hF2), 64'h0909, 64'h0A0A}, 1'b0);
    @(posedge clk); #1;
    rst = 1'b1;
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    tx_q.delete();
    checkResetState();
    repeat (10) @(posedge clk);
    #1;
    checkOutput("reset_no_spurious_rx", MW'(rx_hs - rx_before), 0);
    checkOutput("reset_tx_idle", noc_out_val, 0);
    checkOutput("reset_error_count", MW'(err_pulses), 2);

    $display("%0d/%0d checks passed", pass_count, check_count);
    $finish;
  end

endmodule
